// File: rtl/sdram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_cmd_scheduler
//
// Front end of the SDRAM opcode FSM. Arbitrates two host ports (round-robin)
// against a periodic auto-refresh timer. It presents one opcode at a time to
// the FSM and uses the FSM's idle flag to detect completion.
//
// Optional feature macro: SELF_REF_EN
//   defined   -> sleep_req/sleeping ports, SLEEP state and opcode 2 exist
//   undefined -> no self-refresh; priority is ref_pend > hosts
//
// Parameters
//   REF_INTERVAL  cycles between auto-refresh requests (>= 16)
//   ADDR_W        host/SDRAM address width
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   fsm_idle     opcode FSM sits in READY
//   opcode[2:0]  to opcode FSM: 0 nop/exit, 2 self-ref, 3 auto-ref,
//                4 rd, 5 rd-burst, 6 wr, 7 wr-burst
//   addr_out     address of the granted host command
//   req[1:0]     host requests, held until ack
//   we[1:0]      per host: 1 write, 0 read
//   burst[1:0]   per host: 1 burst, 0 single
//   addr0/addr1  per-host address
//   ack[1:0]     one-cycle pulse when that host's command completes
//   grant_id     host whose command is in flight
//   ref_overrun  sticky: refresh interval expired with refresh still pending
//   sleep_req    (SELF_REF_EN) request self-refresh entry
//   sleeping     (SELF_REF_EN) SDRAM in self-refresh
// -----------------------------------------------------------------------------
module sdram_cmd_scheduler #(
    parameter int REF_INTERVAL = 780,
    parameter int ADDR_W       = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fsm_idle,
    output logic [2:0]        opcode,
    output logic [ADDR_W-1:0] addr_out,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [1:0]        burst,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [1:0]        ack,
    output logic              grant_id,
    output logic              ref_overrun
`ifdef SELF_REF_EN
    ,
    input  logic              sleep_req,
    output logic              sleeping
`endif
);

    localparam int CNT_W = $clog2(REF_INTERVAL);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_SREF  = 3'd2;
    localparam logic [2:0] OP_AREF  = 3'd3;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_SLEEP
    } state_t;

    state_t             r_state_reg;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_ref_cnt_reg;
    logic               r_ref_pend_reg;
    logic               r_ref_overrun_reg;
    logic               r_rr_ptr_reg;
    logic [2:0]         r_cmd_reg;       // opcode chosen in IDLE, driven in ISSUE
    logic               r_cmd_host_reg;  // chosen command belongs to a host
    logic [ADDR_W-1:0]  r_addr_reg;
    logic               r_grant_reg;
    logic [1:0]         r_ack_reg;

    logic               w_sleep_req;
    logic               w_sel;
    logic [2:0]         w_host_cmd [2];
    logic [ADDR_W-1:0]  w_host_addr [2];
    logic               w_load;
    logic               w_load_host;
    logic [2:0]         w_load_cmd;
    logic [2:0]         w_opcode;
    logic               w_sleeping;
    logic [1:0]         w_ack_next;
    logic               w_timer_run;
    logic               w_ref_wrap;
    logic               w_ref_issue;

`ifdef SELF_REF_EN
    assign w_sleep_req = sleep_req;
    assign sleeping    = w_sleeping;
`else
    assign w_sleep_req = 1'b0;
`endif

    // Per-host opcode {1, we, burst} and address.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_host
            assign w_host_cmd[gi]  = {1'b1, we[gi], burst[gi]};
            assign w_host_addr[gi] = (gi == 0) ? addr0 : addr1;
        end
    endgenerate

    // Round-robin: the pointed-at host wins if requesting, otherwise the other.
    assign w_sel = req[r_rr_ptr_reg] ? r_rr_ptr_reg : ~r_rr_ptr_reg;

    // Refresh timer is frozen while the SDRAM refreshes itself.
    assign w_timer_run = (r_state_reg != S_SLEEP);
    assign w_ref_wrap  = w_timer_run && (r_ref_cnt_reg == CNT_W'(REF_INTERVAL - 1));
    assign w_ref_issue = (r_state_reg == S_ISSUE) && (r_cmd_reg == OP_AREF);

    always_comb begin
        w_state_next = r_state_reg;
        w_opcode     = OP_NOP;
        w_sleeping   = 1'b0;
        w_load       = 1'b0;
        w_load_host  = 1'b0;
        w_load_cmd   = OP_NOP;
        w_ack_next   = 2'b00;
        case (r_state_reg)
            S_WAIT_INIT: begin
                if (fsm_idle) w_state_next = S_IDLE;
            end
            S_IDLE: begin
                if (r_ref_pend_reg) begin
                    w_load       = 1'b1;
                    w_load_cmd   = OP_AREF;
                    w_state_next = S_ISSUE;
`ifdef SELF_REF_EN
                end else if (w_sleep_req) begin
                    w_load       = 1'b1;
                    w_load_cmd   = OP_SREF;
                    w_state_next = S_ISSUE;
`endif
                end else if (|req) begin
                    w_load       = 1'b1;
                    w_load_host  = 1'b1;
                    w_load_cmd   = w_host_cmd[w_sel];
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_opcode     = r_cmd_reg;
                w_state_next = (r_cmd_reg == OP_SREF) ? S_SLEEP : S_BUSY;
            end
            S_BUSY: begin
                if (fsm_idle) begin
                    w_state_next = S_IDLE;
                    if (r_cmd_host_reg) w_ack_next[r_grant_reg] = 1'b1;
                end
            end
            S_SLEEP: begin
                if (w_sleep_req) begin
                    w_opcode   = OP_SREF;
                    w_sleeping = 1'b1;
                end else begin
                    // Opcode 0 for one cycle is the self-refresh exit command.
                    w_state_next = S_BUSY;
                end
            end
            default: w_state_next = S_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg       <= S_WAIT_INIT;
            r_ref_cnt_reg     <= '0;
            r_ref_pend_reg    <= 1'b0;
            r_ref_overrun_reg <= 1'b0;
            r_rr_ptr_reg      <= 1'b0;
            r_cmd_reg         <= OP_NOP;
            r_cmd_host_reg    <= 1'b0;
            r_addr_reg        <= '0;
            r_grant_reg       <= 1'b0;
            r_ack_reg         <= 2'b00;
        end else begin
            r_state_reg <= w_state_next;
            r_ack_reg   <= w_ack_next;

            if (w_load) begin
                r_cmd_reg      <= w_load_cmd;
                r_cmd_host_reg <= w_load_host;
                // Host address/grant are captured so they are valid during ISSUE
                // and stay put through refresh or self-refresh commands.
                if (w_load_host) begin
                    r_addr_reg   <= w_host_addr[w_sel];
                    r_grant_reg  <= w_sel;
                    r_rr_ptr_reg <= ~w_sel;
                end
            end

            if (w_timer_run) begin
                if (w_ref_wrap) r_ref_cnt_reg <= '0;
                else            r_ref_cnt_reg <= r_ref_cnt_reg + CNT_W'(1);
            end

            // A wrap in the same cycle as the refresh issue re-arms ref_pend
            // without counting as an overrun.
            if (w_ref_wrap) begin
                r_ref_pend_reg <= 1'b1;
                if (r_ref_pend_reg && !w_ref_issue) r_ref_overrun_reg <= 1'b1;
            end else if (w_ref_issue) begin
                r_ref_pend_reg <= 1'b0;
            end
        end
    end

    assign opcode      = w_opcode;
    assign addr_out    = r_addr_reg;
    assign grant_id    = r_grant_reg;
    assign ack         = r_ack_reg;
    assign ref_overrun = r_ref_overrun_reg;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_scheduler
//
// Scoreboard bench for sdram_cmd_scheduler. Expected issues are queued when
// stimulus is driven; a negedge monitor pops and compares them when the DUT
// issues an opcode, then checks the matching ack. A small behavioural model of
// the opcode FSM drives fsm_idle. Build with +define+SELF_REF_EN to add the
// self-refresh scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_cmd_scheduler;

    localparam int REF_INTERVAL = 64;
    localparam int ADDR_W       = 22;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fsm_idle = 1'b0;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] addr_out;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        burst;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [1:0]        ack;
    logic              grant_id;
    logic              ref_overrun;
`ifdef SELF_REF_EN
    logic              sleep_req = 1'b0;
    logic              sleeping;
`endif

    sdram_cmd_scheduler #(
        .REF_INTERVAL (REF_INTERVAL),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fsm_idle    (fsm_idle),
        .opcode      (opcode),
        .addr_out    (addr_out),
        .req         (req),
        .we          (we),
        .burst       (burst),
        .addr0       (addr0),
        .addr1       (addr1),
        .ack         (ack),
        .grant_id    (grant_id),
        .ref_overrun (ref_overrun)
`ifdef SELF_REF_EN
        ,
        .sleep_req   (sleep_req),
        .sleeping    (sleeping)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        op;
        logic              is_host;
        logic [ADDR_W-1:0] addr;
        logic              gid;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // A host keeps requesting while it has more commands queued than acked.
    int req_total [2];
    int ack_total [2] = '{0, 0};
    assign req[0] = (req_total[0] != ack_total[0]);
    assign req[1] = (req_total[1] != ack_total[1]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic push_exp(input logic [2:0] op, input logic is_host,
                            input logic [ADDR_W-1:0] a, input logic g);
        exp_t ent;
        ent.op = op; ent.is_host = is_host; ent.addr = a; ent.gid = g;
        exp_q.push_back(ent);
    endtask

    // ---------------- monitor + opcode FSM model (negedge) ----------------
    exp_t              cur;
    logic              ack_pending = 1'b0;
    logic [1:0]        ack_exp = 2'b00;
    logic              ack_gid = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    int                lat = 0;
    logic [2:0]        prev_issue_op = 3'd0;
    int                m_init = 5;
    int                m_busy = 0;
    logic              m_sleep = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            fsm_idle      = 1'b0;
            m_init        = 5;
            m_busy        = 0;
            m_sleep       = 1'b0;
            ack_pending   = 1'b0;
            prev_issue_op = 3'd0;
        end else begin
            if (prev_issue_op != 3'd0 && prev_issue_op != 3'd2)
                chk("op_one_cycle", {29'd0, opcode}, 32'd0);
            prev_issue_op = 3'd0;
            if (ack_pending) lat++;

            if (fsm_idle && opcode != 3'd0) begin
                prev_issue_op = opcode;
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", {29'd0, opcode}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    $display("issue  op=%0d addr=0x%0h gid=%0d", opcode, addr_out, grant_id);
                    chk("issue_op", {29'd0, opcode}, {29'd0, cur.op});
                    if (cur.is_host) begin
                        chk("issue_addr", 32'(addr_out), 32'(cur.addr));
                        chk("issue_gid", {31'd0, grant_id}, {31'd0, cur.gid});
                        ack_pending = 1'b1;
                        ack_exp     = 2'b01 << cur.gid;
                        ack_gid     = cur.gid;
                        last_addr   = cur.addr;
                        lat         = 0;
                    end
                end
            end

            if (ack != 2'b00) begin
                if (ack_pending) begin
                    $display("ack    mask=%b latency=%0d", ack, lat);
                    chk("ack_mask", {30'd0, ack}, {30'd0, ack_exp});
                    chk("ack_latency_ge3", {31'd0, (lat >= 3)}, 32'd1);
                    chk("addr_hold", 32'(addr_out), 32'(last_addr));
                    ack_pending = 1'b0;
                    ack_total[ack_gid] = ack_total[ack_gid] + 1;
                end else begin
                    chk("ack_unexpected", {30'd0, ack}, 32'd0);
                end
            end

            // Opcode FSM model: accepts an opcode only while idle.
            if (m_init > 0) begin
                m_init--;
                if (m_init == 0) fsm_idle = 1'b1;
            end else if (fsm_idle) begin
                if (opcode != 3'd0) begin
                    fsm_idle = 1'b0;
                    if (opcode == 3'd2) m_sleep = 1'b1;
                    else m_busy = (busy_q.size() > 0) ? busy_q.pop_front() : 3;
                end
            end else if (m_sleep) begin
                if (opcode == 3'd0) begin
                    m_sleep = 1'b0;
                    m_busy  = 2;
                end
            end else if (m_busy > 1) begin
                m_busy--;
            end else begin
                m_busy   = 0;
                fsm_idle = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_total[0] = ack_total[0];
        req_total[1] = ack_total[1];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!fsm_idle && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", {31'd0, fsm_idle}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic host_cmd(input int h, input logic w, input logic b,
                            input logic [ADDR_W-1:0] a, input int n);
        we[h]    = w;
        burst[h] = b;
        if (h == 0) addr0 = a;
        else        addr1 = a;
        req_total[h] = req_total[h] + n;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || ack_pending) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(exp_q.size()) + {31'd0, ack_pending}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        req_total[0] = 0;
        req_total[1] = 0;
        we = 2'b00; burst = 2'b00; addr0 = '0; addr1 = '0;

        // 1: reset values and quiet init phase
        do_reset();
        @(negedge clk);
        chk("rst_addr_out", 32'(addr_out), 32'd0);
        chk("rst_grant_id", {31'd0, grant_id}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("init_opcode", {29'd0, opcode}, 32'd0);
            chk("init_ack", {30'd0, ack}, 32'd0);
        end
        chk("init_overrun", {31'd0, ref_overrun}, 32'd0);

        // 2: single read-burst from host 0
        do_reset();
        wait_init();
        push_exp(3'd5, 1'b1, 22'h001234, 1'b0);
        host_cmd(0, 1'b0, 1'b1, 22'h001234, 1);
        wait_done("t2_done", 40);

        // 3: both hosts held -> grants 0,1,0,1
        do_reset();
        wait_init();
        push_exp(3'd6, 1'b1, 22'h0AAAAA, 1'b0);
        push_exp(3'd4, 1'b1, 22'h155555, 1'b1);
        push_exp(3'd6, 1'b1, 22'h0AAAAA, 1'b0);
        push_exp(3'd4, 1'b1, 22'h155555, 1'b1);
        host_cmd(0, 1'b1, 1'b0, 22'h0AAAAA, 2);
        host_cmd(1, 1'b0, 1'b0, 22'h155555, 2);
        wait_done("t3_done", 80);

        // 4: refresh wins over a pending host; long busy -> overrun
        do_reset();
        wait_init();
        busy_q.push_back(70);
        busy_q.push_back(140);
        push_exp(3'd4, 1'b1, 22'h02AAAA, 1'b0);
        push_exp(3'd3, 1'b0, '0, 1'b0);
        push_exp(3'd3, 1'b0, '0, 1'b0);
        push_exp(3'd7, 1'b1, 22'h3FFFFF, 1'b1);
        host_cmd(0, 1'b0, 1'b0, 22'h02AAAA, 1);
        repeat (6) @(posedge clk);
        #1 host_cmd(1, 1'b1, 1'b1, 22'h3FFFFF, 1);
        repeat (60) @(negedge clk);
        chk("overrun_early", {31'd0, ref_overrun}, 32'd0);
        wait_done("t4_done", 400);
        chk("overrun_set", {31'd0, ref_overrun}, 32'd1);

`ifdef SELF_REF_EN
        // 5: self-refresh has priority over a host, host served after exit
        do_reset();
        wait_init();
        push_exp(3'd2, 1'b0, '0, 1'b0);
        push_exp(3'd4, 1'b1, 22'h000777, 1'b0);
        sleep_req = 1'b1;
        host_cmd(0, 1'b0, 1'b0, 22'h000777, 1);
        repeat (6) @(negedge clk);
        chk("sleep_opcode", {29'd0, opcode}, 32'd2);
        chk("sleep_flag", {31'd0, sleeping}, 32'd1);
        chk("sleep_ack", {30'd0, ack}, 32'd0);
        @(posedge clk); #1 sleep_req = 1'b0;
        @(negedge clk);
        chk("wake_opcode", {29'd0, opcode}, 32'd0);
        chk("wake_flag", {31'd0, sleeping}, 32'd0);
        wait_done("t5_done", 40);
`endif

        // 6: reset during BUSY -> reset outputs, no ack afterwards
        do_reset();
        wait_init();
        busy_q.push_back(10);
        push_exp(3'd7, 1'b1, 22'h3FFFFF, 1'b1);
        host_cmd(1, 1'b1, 1'b1, 22'h3FFFFF, 1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("t6_issued", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        req_total[0] = ack_total[0];
        req_total[1] = ack_total[1];
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_opcode", {29'd0, opcode}, 32'd0);
        chk("t6_rst_ack", {30'd0, ack}, 32'd0);
        chk("t6_rst_addr", 32'(addr_out), 32'd0);
        chk("t6_rst_gid", {31'd0, grant_id}, 32'd0);
        chk("t6_rst_overrun", {31'd0, ref_overrun}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_no_ack", {30'd0, ack}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
